fft_bitrev_reorder: RTL

Output reorder buffer that sits directly downstream of the last delay-feedback butterfly stage of the pipelined FFT. It accepts the stage's output stream, one sample per cycle in bit-reversed order, and emits each frame in natural order. Two N-word ping-pong banks let one frame fill while the previous one drains, so continuous streaming runs at one sample per clock.

---
 rtl/fft_bitrev_reorder.sv | 84 ++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong reorder buffer turning bit-reversed FFT output into natural order
module fft_bitrev_reorder #(
  parameter int W     = 4,
  parameter int LOG2N = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE = LOG2N'(1);

  logic [W-1:0]     mem0 [N];
  logic [W-1:0]     mem1 [N];
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_en;
  logic             rd_en;
  logic             wr_done;
  logic             rd_done;
  logic [LOG2N-1:0] wr_addr;
  logic [W-1:0]     rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_cnt == CNT_MAX);

  // Read path is combinational from the bank so out_valid rises right after the last write
  assign rd_word  = rd_bank ? mem1[rd_cnt] : mem0[rd_cnt];
  assign out_data = out_valid ? rd_word : '0;

  assign wr_en   = in_valid && in_ready;
  assign rd_en   = out_valid && out_ready;
  assign wr_done = wr_en && (wr_cnt == CNT_MAX);
  assign rd_done = rd_en && out_last;
  assign wr_addr = bitrev(wr_cnt);

  // Writer needs !full and reader needs full, so they never update the same bit
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_addr] <= in_data;
      else         mem0[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_en) wr_cnt <= wr_cnt + CNT_ONE;
      if (rd_en) rd_cnt <= rd_cnt + CNT_ONE;
      if (wr_done) wr_bank <= !wr_bank;
      if (rd_done) rd_bank <= !rd_bank;
    end
  end
endmodule
